// File: rtl/embed_token_streamer.sv
// ----------------------------------------------------------------------------
// embed_token_streamer
//
// Consumer end of the linear-embedding output interface. When the embedding
// stage pulses done_in, the 15 valid rows of the 16x16 Q4.4 token matrix are
// captured into an internal buffer. The block then streams the 15 tokens
// downstream, one 16-element token per valid/ready handshake. A saturating
// positional embedding, indexed by emit position, is added to every token.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   done_in     single-cycle pulse: token_in is valid this cycle
//   token_in    16x16 signed Q4.4 matrix (row 15 is not used)
//   pos_emb     NUM_TOK x DIM signed Q4.4 positional embedding (static)
//   tok_data    registered token being offered downstream
//   tok_valid   tok_data is valid
//   tok_ready   downstream accepts tok_data this cycle
//   tok_idx     emit position 0..NUM_TOK-1 of the current token
//   tok_last    high with tok_valid on the final emit position
//   busy        high from capture until frame_done
//   frame_done  single-cycle pulse after the final token is accepted
//   overrun     sticky: done_in arrived while busy
// ----------------------------------------------------------------------------
module embed_token_streamer #(
    parameter int NUM_TOK   = 15,
    parameter int DIM       = 16,
    parameter bit CLS_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              done_in,
    input  logic signed [7:0] token_in [0:15][0:DIM-1],
    input  logic signed [7:0] pos_emb  [0:NUM_TOK-1][0:DIM-1],
    output logic signed [7:0] tok_data [0:DIM-1],
    output logic              tok_valid,
    input  logic              tok_ready,
    output logic [3:0]        tok_idx,
    output logic              tok_last,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] FIN    = 2'd2;

    localparam logic [3:0] LAST_POS = 4'(NUM_TOK - 1);

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Source row for an emit position. With CLS_FIRST the CLS token (the
    // last valid row) leads the stream and the patch rows follow in order.
    function automatic logic [3:0] row_of(input logic [3:0] p);
        if (CLS_FIRST) begin
            return (p == 4'd0) ? LAST_POS : p - 4'd1;
        end
        return p;
    endfunction

    // Q4.4 + Q4.4 in 9 bits, clamped to the 8-bit signed range. Overflow is
    // visible as disagreement between the two top bits of the 9-bit sum.
    function automatic logic signed [7:0] sat_add(input logic signed [7:0] a,
                                                  input logic signed [7:0] b);
        logic signed [8:0] s;
        s = {a[7], a} + {b[7], b};
        if (s[8] != s[7]) begin
            return s[8] ? 8'sh80 : 8'sh7F;
        end
        return s[7:0];
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]        state_q,      state_d;
    logic signed [7:0] buf_q         [0:NUM_TOK-1][0:DIM-1];
    logic signed [7:0] buf_d         [0:NUM_TOK-1][0:DIM-1];
    logic signed [7:0] tok_data_q    [0:DIM-1];
    logic signed [7:0] tok_data_d    [0:DIM-1];
    logic              tok_valid_q,  tok_valid_d;
    logic [3:0]        tok_idx_q,    tok_idx_d;
    logic              tok_last_q,   tok_last_d;
    logic              busy_q,       busy_d;
    logic              frame_done_q, frame_done_d;
    logic              overrun_q,    overrun_d;

    // Token load control, decided by the FSM and consumed by the datapath.
    logic              load;
    logic              load_from_input;
    logic [3:0]        load_pos;
    logic [3:0]        load_row;
    logic [3:0]        next_idx;
    logic              accept;

    assign accept   = tok_valid_q & tok_ready;
    assign next_idx = tok_idx_q + 4'd1;
    assign load_row = row_of(load_pos);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_d         = state_q;
        buf_d           = buf_q;
        tok_valid_d     = tok_valid_q;
        tok_idx_d       = tok_idx_q;
        tok_last_d      = tok_last_q;
        busy_d          = busy_q;
        frame_done_d    = 1'b0;
        overrun_d       = overrun_q;
        load            = 1'b0;
        load_from_input = 1'b0;
        load_pos        = 4'd0;

        case (state_q)
            IDLE: begin
                if (done_in) begin
                    for (int r = 0; r < NUM_TOK; r++) begin
                        buf_d[r] = token_in[r];
                    end
                    // The buffer is written on this same edge, so the first
                    // token is formed straight from token_in.
                    load            = 1'b1;
                    load_from_input = 1'b1;
                    load_pos        = 4'd0;
                    tok_valid_d     = 1'b1;
                    tok_idx_d       = 4'd0;
                    tok_last_d      = (LAST_POS == 4'd0);
                    busy_d          = 1'b1;
                    state_d         = STREAM;
                end
            end

            STREAM: begin
                if (done_in) begin
                    overrun_d = 1'b1;
                end
                if (accept) begin
                    if (tok_idx_q == LAST_POS) begin
                        tok_valid_d  = 1'b0;
                        tok_last_d   = 1'b0;
                        frame_done_d = 1'b1;
                        state_d      = FIN;
                    end else begin
                        // Reload on the accepting edge: no bubble between tokens.
                        load       = 1'b1;
                        load_pos   = next_idx;
                        tok_idx_d  = next_idx;
                        tok_last_d = (next_idx == LAST_POS);
                    end
                end
            end

            FIN: begin
                if (done_in) begin
                    overrun_d = 1'b1;
                end
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Token datapath: positional embedding added with saturation.
    always_comb begin
        tok_data_d = tok_data_q;
        if (load) begin
            for (int e = 0; e < DIM; e++) begin
                tok_data_d[e] = sat_add(load_from_input ? token_in[load_row][e]
                                                        : buf_q[load_row][e],
                                        pos_emb[load_pos][e]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            tok_valid_q  <= 1'b0;
            tok_idx_q    <= 4'd0;
            tok_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            for (int e = 0; e < DIM; e++) begin
                tok_data_q[e] <= 8'sd0;
            end
        end else begin
            state_q      <= state_d;
            tok_data_q   <= tok_data_d;
            tok_valid_q  <= tok_valid_d;
            tok_idx_q    <= tok_idx_d;
            tok_last_q   <= tok_last_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    // NOTE: the capture buffer is deliberately left out of reset; its
    // contents are only read after a capture has written them, and an
    // unreset array maps to plain storage instead of resettable flops.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign tok_data   = tok_data_q;
    assign tok_valid  = tok_valid_q;
    assign tok_idx    = tok_idx_q;
    assign tok_last   = tok_last_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_embed_token_streamer.sv
// ----------------------------------------------------------------------------
// tb_embed_token_streamer
//
// Two instances: dut_a with CLS row first, dut_b with rows in natural order.
// Stimulus pushes expected tokens into per-instance queues; monitors pop and
// compare on every handshake, and also watch stall stability and the
// frame_done pulse that must follow the last token.
// ----------------------------------------------------------------------------
module tb_embed_token_streamer;

    typedef struct packed {
        logic [15:0][7:0] d;
        logic [3:0]       idx;
        logic             last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              done_a, done_b;
    logic              tok_ready;
    logic signed [7:0] token_in [0:15][0:15];
    logic signed [7:0] pos_emb  [0:14][0:15];

    logic signed [7:0] data_a [0:15];
    logic signed [7:0] data_b [0:15];
    logic              valid_a, last_a, busy_a, fd_a, ov_a;
    logic              valid_b, last_b, busy_b, fd_b, ov_b;
    logic [3:0]        idx_a, idx_b;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    int   hs_a = 0, hs_b = 0, fd_cnt_a = 0, fd_cnt_b = 0;

    always #5 clk = ~clk;

    embed_token_streamer #(.NUM_TOK(15), .DIM(16), .CLS_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .done_in(done_a), .token_in(token_in),
        .pos_emb(pos_emb), .tok_data(data_a), .tok_valid(valid_a),
        .tok_ready(tok_ready), .tok_idx(idx_a), .tok_last(last_a),
        .busy(busy_a), .frame_done(fd_a), .overrun(ov_a)
    );

    embed_token_streamer #(.NUM_TOK(15), .DIM(16), .CLS_FIRST(1'b0)) dut_b (
        .clk(clk), .rst(rst), .done_in(done_b), .token_in(token_in),
        .pos_emb(pos_emb), .tok_data(data_b), .tok_valid(valid_b),
        .tok_ready(tok_ready), .tok_idx(idx_b), .tok_last(last_b),
        .busy(busy_b), .frame_done(fd_b), .overrun(ov_b)
    );

    // ------------------------------------------------------------------
    // Check helpers and reference model
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait expired at %0t", name, $time);
    endtask

    function automatic logic [127:0] pack_tok(input logic signed [7:0] t [0:15]);
        logic [127:0] v;
        for (int e = 0; e < 16; e++) v[e*8 +: 8] = t[e];
        return v;
    endfunction

    function automatic exp_t model(input int p, input bit cls_first);
        exp_t x;
        int   row, s;
        row = cls_first ? ((p == 0) ? 14 : p - 1) : p;
        for (int e = 0; e < 16; e++) begin
            s = int'(token_in[row][e]) + int'(pos_emb[p][e]);
            if (s > 127)  s = 127;
            if (s < -128) s = -128;
            x.d[e] = 8'(s);
        end
        x.idx  = 4'(p);
        x.last = (p == 14);
        return x;
    endfunction

    // ------------------------------------------------------------------
    // Monitors
    // ------------------------------------------------------------------
    logic         pend_fd_a = 1'b0, pend_fd_b = 1'b0, stall_a = 1'b0;
    logic [127:0] stall_data;
    logic [3:0]   stall_idx;

    always @(negedge clk) begin
        exp_t x;
        if (rst) begin
            pend_fd_a = 1'b0;
            stall_a   = 1'b0;
        end else begin
            if (fd_a) fd_cnt_a++;
            if (pend_fd_a) check("frame_done_after_last_a", fd_a, 1'b1);
            if (stall_a && valid_a) begin
                check("stall_data_stable", pack_tok(data_a), stall_data);
                check("stall_idx_stable", idx_a, stall_idx);
            end
            pend_fd_a = 1'b0;
            stall_a   = valid_a && !tok_ready;
            if (stall_a) begin
                stall_data = pack_tok(data_a);
                stall_idx  = idx_a;
            end
            if (valid_a && tok_ready) begin
                hs_a++;
                pend_fd_a = last_a;
                if (q_a.size() == 0) begin
                    timeout("unexpected_token_a");
                end else begin
                    x = q_a.pop_front();
                    check("tok_data_a", pack_tok(data_a), x.d);
                    check("tok_idx_a", idx_a, x.idx);
                    check("tok_last_a", last_a, x.last);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t x;
        if (rst) begin
            pend_fd_b = 1'b0;
        end else begin
            if (fd_b) fd_cnt_b++;
            if (pend_fd_b) check("frame_done_after_last_b", fd_b, 1'b1);
            pend_fd_b = 1'b0;
            if (valid_b && tok_ready) begin
                hs_b++;
                pend_fd_b = last_b;
                if (q_b.size() == 0) begin
                    timeout("unexpected_token_b");
                end else begin
                    x = q_b.pop_front();
                    check("tok_data_b", pack_tok(data_b), x.d);
                    check("tok_idx_b", idx_b, x.idx);
                    check("tok_last_b", last_b, x.last);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic pulse_a();
        @(posedge clk); #1 done_a = 1'b1;
        @(posedge clk); #1 done_a = 1'b0;
    endtask

    task automatic push_frame_a();
        for (int p = 0; p < 15; p++) q_a.push_back(model(p, 1'b1));
    endtask

    // Counts negedges with busy high until it drops; bounded.
    task automatic count_busy_a(output int cnt);
        cnt = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy_a) return;
            cnt++;
        end
        timeout("busy_a_never_dropped");
    endtask

    task automatic wait_idx_a(input logic [3:0] target);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (valid_a && idx_a == target) return;
        end
        timeout("wait_idx_a");
    endtask

    task automatic check_zero_a(input string tag);
        check({tag, "_data"},  pack_tok(data_a), 128'd0);
        check({tag, "_valid"}, valid_a, 1'b0);
        check({tag, "_idx"},   idx_a, 4'd0);
        check({tag, "_last"},  last_a, 1'b0);
        check({tag, "_busy"},  busy_a, 1'b0);
        check({tag, "_fd"},    fd_a, 1'b0);
        check({tag, "_ovr"},   ov_a, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before %0t", $time);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int cnt, hs0, fd0;

        rst = 1'b1; done_a = 1'b0; done_b = 1'b0; tok_ready = 1'b1;
        for (int r = 0; r < 16; r++)
            for (int e = 0; e < 16; e++) token_in[r][e] = 8'(r);
        for (int p = 0; p < 15; p++)
            for (int e = 0; e < 16; e++) pos_emb[p][e] = 8'sd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_zero_a("reset");
        check("reset_b_valid", valid_b, 1'b0);

        // Basic order, CLS first: tokens 14,0,1,...,13.
        hs0 = hs_a; fd0 = fd_cnt_a;
        push_frame_a();
        pulse_a();
        count_busy_a(cnt);
        check("busy_cycles", cnt, 16);
        check("basic_handshakes", hs_a - hs0, 15);
        check("basic_frame_done_pulses", fd_cnt_a - fd0, 1);
        check("basic_queue_empty", q_a.size(), 0);

        // Natural order on the second instance.
        for (int p = 0; p < 15; p++) q_b.push_back(model(p, 1'b0));
        @(posedge clk); #1 done_b = 1'b1;
        @(posedge clk); #1 done_b = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("order_b_handshakes", hs_b, 15);
        check("order_b_frame_done", fd_cnt_b, 1);
        check("order_b_queue_empty", q_b.size(), 0);
        check("order_b_busy_low", busy_b, 1'b0);

        // Saturation: row 0 in three element groups, positive/negative clamp
        // and an in-range sum.
        for (int r = 0; r < 16; r++)
            for (int e = 0; e < 16; e++) token_in[r][e] = 8'(r * 3);
        for (int e = 0; e < 16; e++) begin
            token_in[0][e] = (e < 5) ? 8'sh70 : (e < 10) ? 8'sh90 : 8'sh10;
            for (int p = 0; p < 15; p++)
                pos_emb[p][e] = (e < 5) ? 8'sh20 : (e < 10) ? 8'shE0 : 8'sh08;
        end
        hs0 = hs_a;
        push_frame_a();
        pulse_a();
        count_busy_a(cnt);
        check("sat_handshakes", hs_a - hs0, 15);

        // Backpressure: 1,0,0,1 then random ready.
        for (int r = 0; r < 16; r++)
            for (int e = 0; e < 16; e++) token_in[r][e] = 8'(r * 17 + e * 5);
        for (int p = 0; p < 15; p++)
            for (int e = 0; e < 16; e++) pos_emb[p][e] = 8'(p * 3 - e);
        hs0 = hs_a; fd0 = fd_cnt_a;
        push_frame_a();
        pulse_a();
        begin
            bit pat [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
            int i;
            tok_ready = 1'b1;
            for (i = 0; i < 400 && busy_a; i++) begin
                @(posedge clk); #1;
                tok_ready = (i < 4) ? pat[i] : 1'($urandom_range(0, 1));
            end
            if (busy_a) timeout("backpressure_frame");
        end
        tok_ready = 1'b1;
        check("bp_handshakes", hs_a - hs0, 15);
        check("bp_frame_done_pulses", fd_cnt_a - fd0, 1);
        check("bp_queue_empty", q_a.size(), 0);

        // Overrun: second done_in with other data at position 5.
        for (int r = 0; r < 16; r++)
            for (int e = 0; e < 16; e++) token_in[r][e] = 8'(r + e);
        hs0 = hs_a;
        push_frame_a();
        pulse_a();
        wait_idx_a(4'd5);
        for (int r = 0; r < 16; r++)
            for (int e = 0; e < 16; e++) token_in[r][e] = 8'(-40 - r);
        done_a = 1'b1;
        @(posedge clk); #1 done_a = 1'b0;
        check("overrun_set", ov_a, 1'b1);
        count_busy_a(cnt);
        repeat (3) @(negedge clk);
        check("overrun_sticky", ov_a, 1'b1);
        check("overrun_handshakes", hs_a - hs0, 15);
        check("overrun_queue_empty", q_a.size(), 0);

        // Reset mid-stream at position 7.
        for (int r = 0; r < 16; r++)
            for (int e = 0; e < 16; e++) token_in[r][e] = 8'(r * 2 - e);
        push_frame_a();
        pulse_a();
        wait_idx_a(4'd7);
        rst = 1'b1;
        #1;
        check_zero_a("midrst");
        q_a.delete();
        fd0 = fd_cnt_a;
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_no_frame_done", fd_cnt_a - fd0, 0);
        hs0 = hs_a;
        push_frame_a();
        pulse_a();
        check("restart_valid", valid_a, 1'b1);
        check("restart_idx", idx_a, 4'd0);
        count_busy_a(cnt);
        check("restart_handshakes", hs_a - hs0, 15);
        check("restart_queue_empty", q_a.size(), 0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
